// File: rtl/spi_cmd_decoder.sv
// Byte-level SPI command decoder: pairs a command byte with the following data byte and
// services a small register file (CTRL, MODE, GPIO_OUT, GPIO_IN, WR_CNT).
module spi_cmd_decoder (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       ss,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   input  logic [7:0] gpio_in,
   output logic [7:0] tx_byte,
   output logic [7:0] mode,
   output logic [7:0] gpio_out,
   output logic       soft_rst,
   output logic       cmd_err
);

   localparam logic [3:0] AddrCtrl    = 4'h0;
   localparam logic [3:0] AddrMode    = 4'h1;
   localparam logic [3:0] AddrGpioOut = 4'hB;
   localparam logic [3:0] AddrGpioIn  = 4'hC;
   localparam logic [3:0] AddrWrCnt   = 4'hD;

   typedef enum logic [0:0] {StIdle, StData} state_e;

   state_e     state_q;
   logic       cmd_wr_q;
   logic [3:0] cmd_addr_q;
   logic [7:0] tx_byte_q;
   logic [7:0] mode_q;
   logic [7:0] gpio_out_q;
   logic [7:0] wr_cnt_q;
   logic       soft_rst_q;
   logic       cmd_err_q;
   logic [7:0] gpio_s1_q;
   logic [7:0] gpio_s2_q;

   logic       accept;
   logic       cmd_wr;
   logic [3:0] cmd_addr;
   logic       addr_valid;
   logic       cmd_bad;
   logic [7:0] rd_value;
   logic       wr_ok;

   assign accept   = rx_valid & ss;
   assign cmd_wr   = rx_byte[7];
   assign cmd_addr = rx_byte[3:0];

   // Decode of the incoming byte as a command; only meaningful in StIdle.
   always_comb begin
      addr_valid = 1'b0;
      rd_value   = 8'hFF;
      case (cmd_addr)
         AddrCtrl: begin
            addr_valid = 1'b1;
            rd_value   = 8'h00;
         end
         AddrMode: begin
            addr_valid = 1'b1;
            rd_value   = mode_q;
         end
         AddrGpioOut: begin
            addr_valid = 1'b1;
            rd_value   = gpio_out_q;
         end
         AddrGpioIn: begin
            addr_valid = 1'b1;
            rd_value   = gpio_s2_q;
         end
         AddrWrCnt: begin
            addr_valid = 1'b1;
            rd_value   = wr_cnt_q;
         end
         default: begin
            addr_valid = 1'b0;
            rd_value   = 8'hFF;
         end
      endcase
      cmd_bad = ~addr_valid | (cmd_wr & ((cmd_addr == AddrGpioIn) | (cmd_addr == AddrWrCnt)));
   end

   always_comb begin
      wr_ok = cmd_wr_q & ((cmd_addr_q == AddrCtrl) | (cmd_addr_q == AddrMode) |
                          (cmd_addr_q == AddrGpioOut));
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cmd_wr_q   <= 1'b0;
         cmd_addr_q <= 4'h0;
         tx_byte_q  <= 8'h00;
         mode_q     <= 8'h00;
         gpio_out_q <= 8'h00;
         wr_cnt_q   <= 8'h00;
         soft_rst_q <= 1'b0;
         cmd_err_q  <= 1'b0;
         gpio_s1_q  <= 8'h00;
         gpio_s2_q  <= 8'h00;
      end else begin
         gpio_s1_q  <= gpio_in;
         gpio_s2_q  <= gpio_s1_q;
         soft_rst_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  state_q    <= StData;
                  cmd_wr_q   <= cmd_wr;
                  cmd_addr_q <= cmd_addr;
                  if (cmd_bad) begin
                     cmd_err_q <= 1'b1;
                  end
                  // Write commands report status with the updated error bit plus "pending".
                  if (cmd_wr) begin
                     tx_byte_q <= {cmd_err_q | cmd_bad, 6'b0, 1'b1};
                  end else begin
                     tx_byte_q <= rd_value;
                  end
               end
            end
            StData: begin
               if (!ss) begin
                  state_q   <= StIdle;
                  tx_byte_q <= {cmd_err_q, 7'b0};
               end else if (accept) begin
                  state_q   <= StIdle;
                  tx_byte_q <= {cmd_err_q, 7'b0};
                  if (wr_ok) begin
                     case (cmd_addr_q)
                        AddrCtrl: begin
                           if (rx_byte[0]) begin
                              mode_q     <= 8'h00;
                              gpio_out_q <= 8'h00;
                              wr_cnt_q   <= 8'h00;
                              cmd_err_q  <= 1'b0;
                              soft_rst_q <= 1'b1;
                              tx_byte_q  <= 8'h00;
                           end else if (rx_byte[1]) begin
                              cmd_err_q <= 1'b0;
                              tx_byte_q <= 8'h00;
                           end
                        end
                        AddrMode: begin
                           mode_q   <= rx_byte;
                           wr_cnt_q <= wr_cnt_q + 8'd1;
                        end
                        AddrGpioOut: begin
                           gpio_out_q <= rx_byte;
                           wr_cnt_q   <= wr_cnt_q + 8'd1;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign tx_byte  = tx_byte_q;
   assign mode     = mode_q;
   assign gpio_out = gpio_out_q;
   assign soft_rst = soft_rst_q;
   assign cmd_err  = cmd_err_q;

endmodule
